// File: rtl/pc_pkg.sv
// Shared parallel-counter definitions: thermometer width, count width and a
// reference popcount used by the sorter, counter trees and decoder.
package pc_pkg;

    localparam int unsigned N_THERM  = 15;
    localparam int unsigned CW_THERM = $clog2(N_THERM + 1);
    localparam int unsigned POP_MAXW = 64;

    // Callers zero-extend narrower vectors to POP_MAXW before calling.
    function automatic int unsigned therm_popcount(input logic [POP_MAXW-1:0] v);
        int unsigned c;
        c = 0;
        for (int unsigned i = 0; i < POP_MAXW; i++) begin
            if (v[i]) c++;
        end
        return c;
    endfunction

endpackage

// File: rtl/therm_bubble_check.sv
// Combinational check of a sorted vector: flags non-monotonic (bubbled) codes
// and marks each 0->1 transition walking up from bit 0.
module therm_bubble_check
    import pc_pkg::*;
#(
    parameter int unsigned N = N_THERM
) (
    input  logic [N-1:0] therm,
    output logic         bubble,
    output logic [N-1:0] tx
);

    always_comb begin
        bubble = 1'b0;
        for (int unsigned i = 0; i + 1 < N; i++) begin
            bubble = bubble | (therm[i] & ~therm[i+1]);
        end
        tx = therm & ~{therm[N-2:0], 1'b0};
    end

endmodule

// File: rtl/therm_count_decoder.sv
// Two-stage valid/ready decoder from a thermometer code to a binary ones-count,
// with bubble detection and a saturating bubble-error counter.
module therm_count_decoder
    import pc_pkg::*;
#(
    parameter int unsigned N     = N_THERM,
    parameter int unsigned CW    = $clog2(N + 1),
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_therm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             out_bubble,
    output logic [ERR_W-1:0] err_cnt,
    input  logic             clr_err
);

    logic             s1_valid_q, s1_valid_d;
    logic [N-1:0]     s1_therm_q, s1_therm_d;
    logic             s2_valid_q, s2_valid_d;
    logic [CW-1:0]    s2_count_q, s2_count_d;
    logic             s2_bubble_q, s2_bubble_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic             s1_bubble;
    logic [N-1:0]     s1_tx;
    logic [CW-1:0]    s1_idx;
    logic [CW-1:0]    s1_count;
    logic             s1_adv, s2_adv;

    therm_bubble_check #(.N(N)) u_bubble_check (
        .therm  (s1_therm_q),
        .bubble (s1_bubble),
        .tx     (s1_tx)
    );

    // A legal code has a single transition at N-k; bubbled words fall back to
    // a full popcount so the reported count is still the true ones-count.
    always_comb begin
        s1_idx = '0;
        for (int unsigned j = 0; j < N; j++) begin
            if (s1_tx[j]) s1_idx = s1_idx | CW'(j);
        end
        if (s1_bubble) begin
            s1_count = CW'(therm_popcount(POP_MAXW'(s1_therm_q)));
        end else if (s1_tx == '0) begin
            s1_count = '0;
        end else begin
            s1_count = CW'(N) - s1_idx;
        end
    end

    always_comb begin
        s2_adv = !s2_valid_q || out_ready;
        s1_adv = !s1_valid_q || s2_adv;

        s1_valid_d  = s1_valid_q;
        s1_therm_d  = s1_therm_q;
        s2_valid_d  = s2_valid_q;
        s2_count_d  = s2_count_q;
        s2_bubble_d = s2_bubble_q;
        err_cnt_d   = err_cnt_q;

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) s1_therm_d = in_therm;
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_count_d  = s1_count;
                s2_bubble_d = s1_bubble;
            end
        end

        if (clr_err) begin
            err_cnt_d = '0;
        end else if (s2_valid_q && out_ready && s2_bubble_q && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_therm_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_count_q  <= '0;
            s2_bubble_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_therm_q  <= s1_therm_d;
            s2_valid_q  <= s2_valid_d;
            s2_count_q  <= s2_count_d;
            s2_bubble_q <= s2_bubble_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign in_ready   = s1_adv;
    assign out_valid  = s2_valid_q;
    assign out_count  = s2_count_q;
    assign out_bubble = s2_bubble_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_therm_count_decoder.sv
// Directed and random stimulus for therm_count_decoder with a queue scoreboard
// fed by an independent popcount / canonical-thermometer reference.
module tb_therm_count_decoder;

    localparam int N     = 15;
    localparam int CW    = 4;
    localparam int ERR_W = 8;

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic          bub;
        logic [31:0]   cyc;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_therm;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_count;
    logic             out_bubble;
    logic [ERR_W-1:0] err_cnt;
    logic             clr_err;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;
    int unsigned cyc   = 0;
    int unsigned err_m = 0;
    logic        rst_req = 1'b0;
    logic        lat_chk = 1'b0;
    exp_t        q[$];

    therm_count_decoder #(.N(N), .CW(CW), .ERR_W(ERR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_therm   (in_therm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_count  (out_count),
        .out_bubble (out_bubble),
        .err_cnt    (err_cnt),
        .clr_err    (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [CW-1:0] ref_count(input logic [N-1:0] w);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c = c + {3'b000, w[i]};
        return c;
    endfunction

    function automatic logic [N-1:0] therm_of(input int k);
        logic [N-1:0] m;
        m = '1;
        m = m << (N - k);
        return m;
    endfunction

    function automatic logic ref_bubble(input logic [N-1:0] w);
        return w !== therm_of(int'(ref_count(w)));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: drive after the falling edge, sample 2 time units later,
    // then the rising edge commits whatever transfers were observed.
    task automatic step(input logic v, input logic [N-1:0] w, input logic ordy,
                        input logic clr, output logic acc);
        exp_t e;
        logic otx;
        @(negedge clk);
        rst_n     = ~rst_req;
        in_valid  = v;
        in_therm  = v ? w : 'x;
        out_ready = ordy;
        clr_err   = clr;
        #2;
        acc = 1'b0;
        if (rst_n) begin
            chk("err_cnt", 32'(err_cnt), err_m);
            otx = 1'b0;
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 32'(out_valid), 32'(0));
                end else begin
                    e = q[0];
                    chk("out_count", 32'(out_count), 32'(e.cnt));
                    chk("out_bubble", 32'(out_bubble), 32'(e.bub));
                    if (ordy) begin
                        otx = 1'b1;
                        if (lat_chk) chk("latency", cyc - e.cyc, 32'(2));
                        void'(q.pop_front());
                    end
                end
            end
            if (clr) err_m = 0;
            else if (otx && e.bub && err_m != 255) err_m++;
            acc = v && in_ready;
            if (acc) begin
                e.cnt = ref_count(w);
                e.bub = ref_bubble(w);
                e.cyc = cyc;
                q.push_back(e);
            end
        end else begin
            q.delete();
            err_m = 0;
        end
        cyc++;
    endtask

    task automatic send(input logic [N-1:0] w, input logic ordy);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) step(1'b1, w, ordy, 1'b0, acc);
        if (!acc) chk("send_timeout", 32'(acc), 32'(1));
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 60 && q.size() != 0; i++) step(1'b0, '0, 1'b1, 1'b0, acc);
        step(1'b0, '0, 1'b1, 1'b0, acc);
        chk("drain_empty", q.size(), 32'(0));
    endtask

    initial begin
        logic         acc;
        logic         have_p;
        logic [N-1:0] p;

        rst_n = 1'b0; in_valid = 1'b0; in_therm = '0; out_ready = 1'b0; clr_err = 1'b0;

        rst_req = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0, acc);
        step(1'b0, '0, 1'b0, 1'b0, acc);
        rst_req = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0, acc);
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_count", 32'(out_count), 32'(0));
        chk("rst_out_bubble", 32'(out_bubble), 32'(0));
        chk("rst_err_cnt", 32'(err_cnt), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));

        // Legal codes back-to-back with fixed two-cycle latency.
        lat_chk = 1'b1;
        for (int k = 0; k <= N; k++) send(therm_of(k), 1'b1);
        drain();
        lat_chk = 1'b0;
        chk("legal_err_cnt", 32'(err_cnt), 32'(0));

        send(15'h7F01, 1'b1);
        drain();
        chk("err_after_7f01", 32'(err_cnt), 32'(1));
        send(15'h0001, 1'b1);
        drain();
        chk("err_after_0001", 32'(err_cnt), 32'(2));

        // Backpressure: two words fill S1/S2, then input stalls.
        step(1'b1, therm_of(3), 1'b0, 1'b0, acc);
        chk("stall_acc0", 32'(acc), 32'(1));
        step(1'b1, therm_of(9), 1'b0, 1'b0, acc);
        chk("stall_acc1", 32'(acc), 32'(1));
        for (int i = 0; i < 4; i++) begin
            step(1'b1, therm_of(12), 1'b0, 1'b0, acc);
            chk("stall_in_ready", 32'(in_ready), 32'(0));
            chk("stall_out_valid", 32'(out_valid), 32'(1));
        end
        send(therm_of(12), 1'b1);
        send(15'h00F0, 1'b1);
        send(therm_of(15), 1'b1);
        drain();

        // Saturation of the bubble counter.
        for (int i = 0; i < 260; i++) send(15'h0001 | 15'(i << 1), 1'b1);
        drain();
        chk("err_saturated", 32'(err_cnt), 32'(255));
        send(15'h0003, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, acc);
        step(1'b0, '0, 1'b1, 1'b1, acc);
        chk("clr_cycle_out_valid", 32'(out_valid), 32'(1));
        step(1'b0, '0, 1'b1, 1'b0, acc);
        chk("err_cleared", 32'(err_cnt), 32'(0));

        // Reset with words in flight.
        send(15'h0005, 1'b1);
        drain();
        step(1'b1, therm_of(4), 1'b0, 1'b0, acc);
        step(1'b1, 15'h0011, 1'b0, 1'b0, acc);
        rst_req = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0, acc);
        rst_req = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0, acc);
        chk("midrst_out_valid", 32'(out_valid), 32'(0));
        chk("midrst_err_cnt", 32'(err_cnt), 32'(0));
        chk("midrst_in_ready", 32'(in_ready), 32'(1));
        send(15'h7FFF, 1'b1);
        drain();

        // Random mixed traffic, valid held until accepted.
        have_p = 1'b0;
        p = '0;
        for (int i = 0; i < 400; i++) begin
            if (!have_p && $urandom_range(0, 2) != 0) begin
                if ($urandom_range(0, 2) == 0) p = N'($urandom);
                else p = therm_of(int'($urandom_range(0, N)));
                have_p = 1'b1;
            end
            step(have_p, p, ($urandom_range(0, 3) != 0), 1'b0, acc);
            if (acc) have_p = 1'b0;
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/therm_count_decoder.md
Name: therm_count_decoder

Overview:
- Consumer end of the sorting-network parallel counter. It takes the sorted 1-bit vector from a sorter stage, a thermometer code with ones packed toward the top index, and decodes it to a binary ones-count.
- Two-stage pipeline with valid/ready handshakes on both sides.
- Flags bubbled (non-monotonic) codes and keeps a saturating error count so sorter faults are visible in system test.

Parameters:
- N, 15, thermometer width (number of sorter outputs).
- CW, $clog2(N+1) = 4, width of the decoded count.
- ERR_W, 8, width of the saturating bubble-error counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  in_therm holds a word.
- in_ready  output  1  block accepts in_therm this cycle.
- in_therm  input  N  sorted vector; a legal code is bits [N-1:N-k] = 1 and the rest 0, for k in 0..N.
- out_valid  output  1  out_count / out_bubble valid.
- out_ready  input  1  downstream accepts this cycle.
- out_count  output  CW  number of ones in the accepted word (0..N).
- out_bubble  output  1  accepted word was not a legal thermometer code.
- err_cnt  output  ERR_W  saturating count of bubbled words delivered.
- clr_err  input  1  synchronous clear of err_cnt.

Behaviour:
- Reset (rst_n=0 at a rising edge): s1_valid=0, s2_valid=0, out_valid=0, out_count=0, out_bubble=0, err_cnt=0. in_ready=1 in the first cycle after reset. Reset mid-operation discards any in-flight words; no partial output appears.
- Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Stage 1 (S1) registers in_therm and computes two things:
  - bubble = OR over i in 0..N-2 of (in_therm[i] && !in_therm[i+1]).
  - tx = one-hot transition vector: bit j set where in_therm[j]=1 and (j=0 or in_therm[j-1]=0).
- Stage 2 (S2) registers the count and bubble:
  - Legal word: count = N - (index of the set bit in tx), or 0 if tx==0.
  - Bubbled word: count = popcount of the S1 word, so the output is still the true ones-count.
- Latency: a word accepted at edge t is presented with out_valid=1 after edge t+2 when not stalled. Throughput is one word per cycle.
- Flow control:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, which is combinational from out_ready and state.
  - No word is dropped or duplicated.
- Internal bubbles collapse: an empty S2 accepts S1 even while out_ready=0.
- Stall: while out_valid && !out_ready, out_count and out_bubble hold stable and out_valid stays 1.
- err_cnt:
  - Increments by 1 on each output transfer with out_bubble=1.
  - Saturates at 2^ERR_W-1 and never wraps.
  - If clr_err and an increment occur in the same cycle, the clear wins and err_cnt=0.
- Edge codes:
  - All-zero word: count 0, bubble 0.
  - All-ones word: count N, bubble 0.
  - Only in_therm[0] set: bubble 1, count 1.
- in_therm is only sampled on a transfer. X on in_therm while in_valid=0 must not propagate.

Decomposition:
- Shared package pc_pkg holds N_THERM=15, CW_THERM, and the function therm_popcount. The package is reused by the sorter and the counter trees.
- One natural combinational sub-module, therm_bubble_check. It takes N bits and returns bubble and the one-hot transition vector. S1 instantiates it.
- The pipeline registers, handshake and err_cnt live in the top module.

Test Plan:
- Reset, then stream k=0..15 legal codes back-to-back with out_ready=1 -> out_count 0..15 in order, each 2 cycles after acceptance; out_bubble=0; err_cnt=0.
- Send 15'h7F01 (illegal) -> out_count=8, out_bubble=1, err_cnt=1. Send 15'h0001 -> count 1, bubble 1, err_cnt=2.
- Stream 5 words, hold out_ready=0 for 4 cycles -> in_ready drops after S1/S2 fill (2 words held). Outputs stay stable during the stall. All 5 counts emerge in order with none lost.
- Send 260 bubbled words with ERR_W=8 -> err_cnt stops at 255. clr_err pulsed on a cycle with a bubbled output transfer -> err_cnt=0.
- Assert rst_n=0 with 2 words in flight and out_ready=0 -> next cycle out_valid=0, err_cnt=0, in_ready=1. A new word 15'h7FFF then yields count 15.
- Random legal/illegal traffic with random in_valid/out_ready against a popcount reference model -> every count and bubble flag matches, and the transfer order is preserved.
